// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder with start/busy/done handshake
// One full-adder cell and a registered carry; one operand bit per clock, LSB first.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry_reg;
  logic [CW-1:0]    cnt;
  logic             bit_sum;
  logic             bit_carry;

  assign bit_sum   = a_sr[0] ^ b_sr[0] ^ carry_reg;
  assign bit_carry = (a_sr[0] & b_sr[0]) | (carry_reg & (a_sr[0] ^ b_sr[0]));

  // New sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign acc_next = bit_sum;
    end else begin : g_wide
      assign acc_next = {bit_sum, acc[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      acc       <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr      <= a;
            b_sr      <= b;
            carry_reg <= carry_in;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          carry_reg <= bit_carry;
          acc       <= acc_next;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum       <= acc_next;
            carry_out <= bit_carry;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at WIDTH=4 and WIDTH=1
module tb_serial_adder;

  localparam int WAIT_MAX = 30;

  logic       clk;
  logic       reset;
  logic       start4, cin4, busy4, done4, co4;
  logic [3:0] a4, b4, sum4;
  logic       start1, cin1, busy1, done1, co1;
  logic [0:0] a1, b1, sum1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] last4 = '0;

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .carry_in(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(co4)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .carry_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(co1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issues one WIDTH=4 operation and reports what was seen; callers do the comparisons.
  task automatic run_op4(input logic [3:0] ia, input logic [3:0] ib, input logic ic,
                         output logic [3:0] s, output logic co, output int nbusy,
                         output int lat, output int hold_bad, output logic done_after);
    s = 'x; co = 1'bx; nbusy = 0; lat = -1; hold_bad = 0;
    @(negedge clk);
    start4 = 1'b1; a4 = ia; b4 = ib; cin4 = ic;
    for (int k = 1; k <= WAIT_MAX; k++) begin
      @(negedge clk);
      start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      if (busy4) begin
        nbusy++;
        if ({co4, sum4} !== last4) hold_bad++;
      end
      if (done4) begin
        lat = k; s = sum4; co = co4;
        break;
      end
    end
    @(negedge clk);
    done_after = done4;
  endtask

  task automatic test_reset;
    reset = 1'b1; start4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'b1;
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy4, done4, co4, sum4} !== 7'd0) begin
        n_bad++; $display("FAIL reset_w4 cyc%0d: busy/done/co/sum=%b required 0", c, {busy4, done4, co4, sum4});
      end
      n_cmp++;
      if ({busy1, done1, co1, sum1} !== 4'd0) begin
        n_bad++; $display("FAIL reset_w1 cyc%0d: busy/done/co/sum=%b required 0", c, {busy1, done1, co1, sum1});
      end
    end
    reset = 1'b0; start4 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      n_bad++; $display("FAIL reset_release: busy=%b done=%b required 0 0", busy4, done4);
    end
    last4 = '0;
  endtask

  task automatic test_vectors(input string name, input logic [8:0] vec [2]);
    logic [3:0] s; logic co; int nb, lat, hb; logic da;
    logic [4:0] exp;
    for (int i = 0; i < 2; i++) begin
      exp = 5'(vec[i][3:0]) + 5'(vec[i][7:4]) + 5'(vec[i][8]);
      run_op4(vec[i][3:0], vec[i][7:4], vec[i][8], s, co, nb, lat, hb, da);
      n_cmp++;
      if ({co, s} !== exp) begin
        n_bad++; $display("FAIL %s_result[%0d]: got %b_%b required %b_%b", name, i, co, s, exp[4], exp[3:0]);
      end
      n_cmp++;
      if (nb !== 4 || lat !== 5 || da !== 1'b0) begin
        n_bad++; $display("FAIL %s_timing[%0d]: busy=%0d lat=%0d done_after=%b required 4 5 0", name, i, nb, lat, da);
      end
      n_cmp++;
      if (hb !== 0) begin
        n_bad++; $display("FAIL %s_hold[%0d]: %0d busy cycles changed result, required 0", name, i, hb);
      end
      last4 = exp;
    end
  endtask

  task automatic test_basic;
    logic [8:0] v [2];
    v[0] = {1'b0, 4'b0101, 4'b0011};
    v[1] = {1'b1, 4'b1111, 4'b1111};
    test_vectors("basic", v);
  endtask

  task automatic test_carry;
    logic [8:0] v [2];
    v[0] = {1'b0, 4'b0001, 4'b1111};
    v[1] = {1'b1, 4'b0000, 4'b0000};
    test_vectors("carry", v);
  endtask

  task automatic test_random;
    logic [3:0] s, ra, rb; logic co, rc; int nb, lat, hb; logic da;
    logic [4:0] exp;
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
      exp = 5'(ra) + 5'(rb) + 5'(rc);
      repeat ($urandom_range(2, 0)) @(negedge clk);
      run_op4(ra, rb, rc, s, co, nb, lat, hb, da);
      n_cmp++;
      if ({co, s} !== exp || nb !== 4 || lat !== 5 || hb !== 0) begin
        n_bad++;
        $display("FAIL random[%0d] %0d+%0d+%0d: got %0d busy=%0d lat=%0d hold_bad=%0d required %0d 4 5 0",
                 i, ra, rb, rc, {co, s}, nb, lat, hb, exp);
      end
      last4 = exp;
    end
  endtask

  task automatic test_handshake;
    int dcount;
    logic [4:0] got;
    dcount = 0; got = 'x;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd4; cin4 = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd9; cin4 = 1'b1;
      end else begin
        start4 = 1'b0;
      end
      if (done4) begin
        dcount++; got = {co4, sum4};
      end
    end
    n_cmp++;
    if (dcount !== 1) begin
      n_bad++; $display("FAIL handshake_done_count: got %0d required 1", dcount);
    end
    n_cmp++;
    if (got !== 5'd7) begin
      n_bad++; $display("FAIL handshake_result: got %0d required 7", got);
    end
    last4 = 5'd7;
  endtask

  task automatic test_reset_mid;
    int dcount;
    logic [3:0] s; logic co; int nb, lat, hb; logic da;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd5; b4 = 4'd6; cin4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    n_cmp++;
    if (busy4 !== 1'b1) begin
      n_bad++; $display("FAIL reset_mid_busy_before: got %b required 1", busy4);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({busy4, done4, co4, sum4} !== 7'd0) begin
      n_bad++; $display("FAIL reset_mid_cleared: busy/done/co/sum=%b required 0", {busy4, done4, co4, sum4});
    end
    dcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (done4) dcount++;
    end
    n_cmp++;
    if (dcount !== 0) begin
      n_bad++; $display("FAIL reset_mid_no_done: got %0d pulses required 0", dcount);
    end
    last4 = '0;
    run_op4(4'd2, 4'd2, 1'b0, s, co, nb, lat, hb, da);
    n_cmp++;
    if ({co, s} !== 5'd4 || lat !== 5) begin
      n_bad++; $display("FAIL reset_mid_after: got %0d lat=%0d required 4 5", {co, s}, lat);
    end
    last4 = 5'd4;
  endtask

  task automatic test_back_to_back;
    int order [512];
    int idx, cyc, prev, tmp, j;
    logic [4:0] exp;
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    @(negedge clk);
    start4 = 1'b1;
    a4 = order[0][3:0]; b4 = order[0][7:4]; cin4 = order[0][8];
    idx = 0; cyc = 0; prev = 0;
    while (idx < 512 && cyc < 512 * 6 + 50) begin
      @(negedge clk);
      cyc++;
      if (done4) begin
        exp = 5'(order[idx][3:0]) + 5'(order[idx][7:4]) + 5'(order[idx][8]);
        n_cmp++;
        if ({co4, sum4} !== exp) begin
          n_bad++; $display("FAIL b2b_w4_result[%0d]: got %0d required %0d", order[idx], {co4, sum4}, exp);
        end
        n_cmp++;
        if (cyc - prev !== ((idx == 0) ? 5 : 6)) begin
          n_bad++; $display("FAIL b2b_w4_interval[%0d]: got %0d required %0d", idx, cyc - prev, (idx == 0) ? 5 : 6);
        end
        prev = cyc; last4 = exp; idx++;
        if (idx < 512) begin
          a4 = order[idx][3:0]; b4 = order[idx][7:4]; cin4 = order[idx][8];
        end else begin
          start4 = 1'b0;
        end
      end
    end
    start4 = 1'b0;
    n_cmp++;
    if (idx !== 512) begin
      n_bad++; $display("FAIL b2b_w4_timeout: completed %0d required 512", idx);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back_w1;
    int order [32];
    int idx, cyc, prev, tmp, j;
    logic [1:0] exp;
    for (int i = 0; i < 32; i++) order[i] = i % 8;
    for (int i = 31; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    @(negedge clk);
    start1 = 1'b1;
    a1 = order[0][0]; b1 = order[0][1]; cin1 = order[0][2];
    idx = 0; cyc = 0; prev = 0;
    while (idx < 32 && cyc < 32 * 3 + 20) begin
      @(negedge clk);
      cyc++;
      if (done1) begin
        exp = 2'(order[idx][0]) + 2'(order[idx][1]) + 2'(order[idx][2]);
        n_cmp++;
        if ({co1, sum1} !== exp) begin
          n_bad++; $display("FAIL b2b_w1_result[%0d]: got %0d required %0d", idx, {co1, sum1}, exp);
        end
        n_cmp++;
        if (cyc - prev !== ((idx == 0) ? 2 : 3)) begin
          n_bad++; $display("FAIL b2b_w1_interval[%0d]: got %0d required %0d", idx, cyc - prev, (idx == 0) ? 2 : 3);
        end
        prev = cyc; idx++;
        if (idx < 32) begin
          a1 = order[idx][0]; b1 = order[idx][1]; cin1 = order[idx][2];
        end else begin
          start1 = 1'b0;
        end
      end
    end
    start1 = 1'b0;
    n_cmp++;
    if (idx !== 32) begin
      n_bad++; $display("FAIL b2b_w1_timeout: completed %0d required 32", idx);
    end
  endtask

  initial begin
    reset = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_handshake();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_back_to_back_w1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
